// File: rtl/if_fetch_unit_if.sv
// Instruction-memory read port: word request/acknowledge handshake between
// the fetch stage (master) and instruction memory (slave).
interface if_fetch_unit_if;
  logic        req;
  logic [29:0] addr;
  logic        ack;
  logic [31:0] rd_data;

  modport master (output req, addr, input ack, rd_data);
  modport slave  (input req, addr, output ack, rd_data);
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, reads instruction memory over a
// req/ack handshake and presents {if_pc, if_insn, if_en} to decode.
//
// state | meaning
// ------+----------------------------------------------------------------
// REQ   | request at pc outstanding; ack delivers insn (or buffers it on stall)
// HOLD  | fetched insn parked in hold buffer while decode stalls; no request
// DROP  | abandoned read at req_addr still in flight; wait for its ack
module if_fetch_unit #(
  parameter logic [29:0] RESET_PC = 30'h0,
  parameter logic [31:0] NOP_INSN = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  flush,
  input  logic [29:0]           new_pc,
  input  logic                  br_taken,
  input  logic [29:0]           br_addr,
  if_fetch_unit_if.master       imem,
  output logic [29:0]           if_pc,
  output logic [31:0]           if_insn,
  output logic                  if_en,
  output logic                  if_busy
);

  typedef enum logic [1:0] {ST_REQ, ST_HOLD, ST_DROP} state_t;

  state_t      state, state_nxt;
  logic [29:0] pc, pc_nxt;
  logic [29:0] req_addr, req_addr_nxt;
  logic [31:0] hold_insn, hold_insn_nxt;
  logic [29:0] hold_pc, hold_pc_nxt;
  logic [29:0] if_pc_nxt;
  logic [31:0] if_insn_nxt;
  logic        if_en_nxt;
  logic [29:0] pc_inc;

  assign pc_inc = pc + 30'd1;

  // Next-state, next-register values and memory/busy outputs.
  always_comb begin
    state_nxt     = state;
    pc_nxt        = pc;
    req_addr_nxt  = req_addr;
    hold_insn_nxt = hold_insn;
    hold_pc_nxt   = hold_pc;
    if_pc_nxt     = if_pc;
    if_insn_nxt   = if_insn;
    if_en_nxt     = if_en;
    imem.req      = 1'b0;
    imem.addr     = pc;
    if_busy       = 1'b0;

    case (state)
      ST_REQ: begin
        imem.req     = 1'b1;
        imem.addr    = pc;
        if_busy      = ~imem.ack;
        req_addr_nxt = pc;
        if (flush) begin
          pc_nxt      = new_pc;
          if_en_nxt   = 1'b0;
          if_insn_nxt = NOP_INSN;
          state_nxt   = imem.ack ? ST_REQ : ST_DROP;
        end else if (stall) begin
          if (imem.ack) begin
            hold_insn_nxt = imem.rd_data;
            hold_pc_nxt   = pc_inc;
            pc_nxt        = pc_inc;
            state_nxt     = ST_HOLD;
          end
        end else if (br_taken) begin
          pc_nxt      = br_addr;
          if_en_nxt   = 1'b0;
          if_insn_nxt = NOP_INSN;
          state_nxt   = imem.ack ? ST_REQ : ST_DROP;
        end else if (imem.ack) begin
          if_insn_nxt = imem.rd_data;
          if_pc_nxt   = pc_inc;
          if_en_nxt   = 1'b1;
          pc_nxt      = pc_inc;
        end else begin
          if_en_nxt   = 1'b0;
          if_insn_nxt = NOP_INSN;
        end
      end

      ST_HOLD: begin
        if (flush) begin
          pc_nxt      = new_pc;
          if_en_nxt   = 1'b0;
          if_insn_nxt = NOP_INSN;
          state_nxt   = ST_REQ;
        end else if (stall) begin
          state_nxt = ST_HOLD;
        end else if (br_taken) begin
          pc_nxt      = br_addr;
          if_en_nxt   = 1'b0;
          if_insn_nxt = NOP_INSN;
          state_nxt   = ST_REQ;
        end else begin
          if_insn_nxt = hold_insn;
          if_pc_nxt   = hold_pc;
          if_en_nxt   = 1'b1;
          state_nxt   = ST_REQ;
        end
      end

      ST_DROP: begin
        // Keep the abandoned address on the bus so the handshake stays legal;
        // redirects only retarget pc for the fetch that follows.
        imem.req  = 1'b1;
        imem.addr = req_addr;
        if_busy   = 1'b1;
        if_en_nxt = 1'b0;
        if (flush) begin
          pc_nxt = new_pc;
        end else if (!stall && br_taken) begin
          pc_nxt = br_addr;
        end
        if (imem.ack) begin
          state_nxt = ST_REQ;
        end
      end

      default: state_nxt = ST_REQ;
    endcase

    if (reset) begin
      imem.req = 1'b0;
      if_busy  = 1'b0;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_REQ;
      pc        <= RESET_PC;
      req_addr  <= RESET_PC;
      hold_insn <= NOP_INSN;
      hold_pc   <= RESET_PC;
      if_pc     <= RESET_PC;
      if_insn   <= NOP_INSN;
      if_en     <= 1'b0;
    end else begin
      state     <= state_nxt;
      pc        <= pc_nxt;
      req_addr  <= req_addr_nxt;
      hold_insn <= hold_insn_nxt;
      hold_pc   <= hold_pc_nxt;
      if_pc     <= if_pc_nxt;
      if_insn   <= if_insn_nxt;
      if_en     <= if_en_nxt;
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for the instruction-fetch stage: directed scenarios followed by a
// randomized run against a behavioural model of the fetch rules.
module tb_if_fetch_unit;
  localparam logic [29:0] RST_PC = 30'h0;
  localparam logic [31:0] NOP    = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset, stall, flush, br_taken;
  logic [29:0] new_pc, br_addr;
  logic [29:0] if_pc;
  logic [31:0] if_insn;
  logic        if_en, if_busy;

  int checks = 0;
  int errors = 0;

  if_fetch_unit_if imem ();

  if_fetch_unit #(.RESET_PC(RST_PC), .NOP_INSN(NOP)) dut (
    .clk      (clk),
    .reset    (reset),
    .stall    (stall),
    .flush    (flush),
    .new_pc   (new_pc),
    .br_taken (br_taken),
    .br_addr  (br_addr),
    .imem     (imem),
    .if_pc    (if_pc),
    .if_insn  (if_insn),
    .if_en    (if_en),
    .if_busy  (if_busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [29:0] a);
    return {a[13:0], 2'b01, a[29:14]} ^ 32'hC3A5_5A3C;
  endfunction

  task automatic drive(input logic st, input logic fl, input logic [29:0] npc,
                       input logic br, input logic [29:0] ba,
                       input logic ack, input logic [31:0] data);
    stall = st; flush = fl; new_pc = npc; br_taken = br; br_addr = ba;
    imem.ack = ack; imem.rd_data = data;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(0, 0, 30'h0, 0, 30'h0, 0, 32'h0);
    tick();
    checks++; if (imem.req !== 1'b0) begin errors++; $display("FAIL rst_req got %b exp 0", imem.req); end
    checks++; if (if_busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", if_busy); end
    checks++; if (if_en !== 1'b0) begin errors++; $display("FAIL rst_en got %b exp 0", if_en); end
    checks++; if (if_insn !== NOP) begin errors++; $display("FAIL rst_insn got %h exp %h", if_insn, NOP); end
    checks++; if (if_pc !== RST_PC) begin errors++; $display("FAIL rst_pc got %h exp %h", if_pc, RST_PC); end
    checks++; if (imem.addr !== RST_PC) begin errors++; $display("FAIL rst_addr got %h exp %h", imem.addr, RST_PC); end
    drive(0, 0, 30'h0, 0, 30'h0, 1, 32'hFFFF_FFFF);
    checks++; if (if_busy !== 1'b0) begin errors++; $display("FAIL rst_busy_ack got %b exp 0", if_busy); end
    checks++; if (imem.req !== 1'b0) begin errors++; $display("FAIL rst_req_ack got %b exp 0", imem.req); end
    tick();
    reset = 1'b0;
    drive(0, 0, 30'h0, 0, 30'h0, 0, 32'h0);
    checks++; if (imem.req !== 1'b1) begin errors++; $display("FAIL post_rst_req got %b exp 1", imem.req); end
    checks++; if (if_en !== 1'b0) begin errors++; $display("FAIL post_rst_en got %b exp 0", if_en); end
  endtask

  task automatic test_zero_wait();
    logic [31:0] d;
    for (int i = 0; i < 3; i++) begin
      d = 32'hA000_0000 + 32'(i);
      drive(0, 0, 30'h0, 0, 30'h0, 1, d);
      checks++; if (imem.addr !== 30'(i)) begin errors++; $display("FAIL zw_addr%0d got %h exp %h", i, imem.addr, i); end
      checks++; if (if_busy !== 1'b0) begin errors++; $display("FAIL zw_busy%0d got %b exp 0", i, if_busy); end
      tick();
      checks++; if (if_en !== 1'b1) begin errors++; $display("FAIL zw_en%0d got %b exp 1", i, if_en); end
      checks++; if (if_insn !== d) begin errors++; $display("FAIL zw_insn%0d got %h exp %h", i, if_insn, d); end
      checks++; if (if_pc !== 30'(i + 1)) begin errors++; $display("FAIL zw_pc%0d got %h exp %h", i, if_pc, i + 1); end
    end
    drive(0, 0, 30'h0, 0, 30'h0, 0, 32'h0);
    checks++; if (if_busy !== 1'b1) begin errors++; $display("FAIL zw_busy_wait got %b exp 1", if_busy); end
    tick();
    checks++; if (if_en !== 1'b0) begin errors++; $display("FAIL zw_bubble_en got %b exp 0", if_en); end
    checks++; if (if_insn !== NOP) begin errors++; $display("FAIL zw_bubble_insn got %h exp %h", if_insn, NOP); end
  endtask

  task automatic test_stall_hold();
    logic [31:0] d, x, e;
    d = 32'hD0D0_0003; x = 32'h5A5A_1234; e = 32'hE000_0005;
    drive(0, 0, 30'h0, 0, 30'h0, 1, d);
    tick();
    drive(1, 0, 30'h0, 0, 30'h0, 1, x);
    checks++; if (imem.addr !== 30'h4) begin errors++; $display("FAIL sh_addr got %h exp 4", imem.addr); end
    tick();
    for (int i = 0; i < 3; i++) begin
      checks++; if (if_en !== 1'b1) begin errors++; $display("FAIL sh_en%0d got %b exp 1", i, if_en); end
      checks++; if (if_insn !== d) begin errors++; $display("FAIL sh_insn%0d got %h exp %h", i, if_insn, d); end
      checks++; if (if_pc !== 30'h4) begin errors++; $display("FAIL sh_pc%0d got %h exp 4", i, if_pc); end
      checks++; if (imem.req !== 1'b0) begin errors++; $display("FAIL sh_req%0d got %b exp 0", i, imem.req); end
      checks++; if (if_busy !== 1'b0) begin errors++; $display("FAIL sh_busy%0d got %b exp 0", i, if_busy); end
      if (i < 2) begin
        drive(1, 0, 30'h0, 0, 30'h0, 0, 32'h0);
        tick();
      end
    end
    drive(0, 0, 30'h0, 0, 30'h0, 0, 32'h0);
    tick();
    checks++; if (if_insn !== x) begin errors++; $display("FAIL sh_rel_insn got %h exp %h", if_insn, x); end
    checks++; if (if_pc !== 30'h5) begin errors++; $display("FAIL sh_rel_pc got %h exp 5", if_pc); end
    checks++; if (if_en !== 1'b1) begin errors++; $display("FAIL sh_rel_en got %b exp 1", if_en); end
    checks++; if (imem.req !== 1'b1) begin errors++; $display("FAIL sh_rel_req got %b exp 1", imem.req); end
    checks++; if (imem.addr !== 30'h5) begin errors++; $display("FAIL sh_rel_addr got %h exp 5", imem.addr); end
    drive(0, 0, 30'h0, 0, 30'h0, 1, e);
    tick();
    checks++; if (if_insn !== e) begin errors++; $display("FAIL sh_resume_insn got %h exp %h", if_insn, e); end
    checks++; if (if_pc !== 30'h6) begin errors++; $display("FAIL sh_resume_pc got %h exp 6", if_pc); end
  endtask

  task automatic test_branch();
    logic [31:0] f;
    f = 32'hF000_0100;
    drive(0, 0, 30'h0, 1, 30'h100, 1, 32'hBAD0_0006);
    tick();
    checks++; if (if_en !== 1'b0) begin errors++; $display("FAIL br_en got %b exp 0", if_en); end
    checks++; if (if_insn !== NOP) begin errors++; $display("FAIL br_insn got %h exp %h", if_insn, NOP); end
    checks++; if (imem.addr !== 30'h100) begin errors++; $display("FAIL br_addr got %h exp 100", imem.addr); end
    drive(1, 0, 30'h0, 1, 30'h3F0, 0, 32'h0);
    tick();
    checks++; if (imem.addr !== 30'h100) begin errors++; $display("FAIL br_stall_ignored got %h exp 100", imem.addr); end
    drive(0, 0, 30'h0, 0, 30'h0, 1, f);
    tick();
    checks++; if (if_insn !== f) begin errors++; $display("FAIL br_tgt_insn got %h exp %h", if_insn, f); end
    checks++; if (if_pc !== 30'h101) begin errors++; $display("FAIL br_tgt_pc got %h exp 101", if_pc); end
  endtask

  task automatic test_flush_drop();
    logic [31:0] g;
    g = 32'h6000_0040;
    drive(0, 0, 30'h0, 1, 30'h8, 1, 32'hBAD0_0101);
    tick();
    drive(0, 1, 30'h40, 0, 30'h0, 0, 32'h0);
    checks++; if (imem.addr !== 30'h8) begin errors++; $display("FAIL fd_addr_pre got %h exp 8", imem.addr); end
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 30'h0, 0, 30'h0, 0, 32'h0);
      checks++; if (imem.req !== 1'b1) begin errors++; $display("FAIL fd_req%0d got %b exp 1", i, imem.req); end
      checks++; if (imem.addr !== 30'h8) begin errors++; $display("FAIL fd_addr%0d got %h exp 8", i, imem.addr); end
      checks++; if (if_busy !== 1'b1) begin errors++; $display("FAIL fd_busy%0d got %b exp 1", i, if_busy); end
      checks++; if (if_en !== 1'b0) begin errors++; $display("FAIL fd_en%0d got %b exp 0", i, if_en); end
      tick();
    end
    drive(0, 0, 30'h0, 0, 30'h0, 1, 32'hDEAD_0008);
    checks++; if (imem.addr !== 30'h8) begin errors++; $display("FAIL fd_addr_ack got %h exp 8", imem.addr); end
    checks++; if (if_busy !== 1'b1) begin errors++; $display("FAIL fd_busy_ack got %b exp 1", if_busy); end
    tick();
    checks++; if (if_en !== 1'b0) begin errors++; $display("FAIL fd_discard_en got %b exp 0", if_en); end
    checks++; if (imem.addr !== 30'h40) begin errors++; $display("FAIL fd_restart_addr got %h exp 40", imem.addr); end
    drive(0, 0, 30'h0, 0, 30'h0, 1, g);
    tick();
    checks++; if (if_en !== 1'b1) begin errors++; $display("FAIL fd_new_en got %b exp 1", if_en); end
    checks++; if (if_insn !== g) begin errors++; $display("FAIL fd_new_insn got %h exp %h", if_insn, g); end
    checks++; if (if_pc !== 30'h41) begin errors++; $display("FAIL fd_new_pc got %h exp 41", if_pc); end
  endtask

  task automatic test_flush_stall_hold();
    logic [31:0] k;
    k = 32'h4B00_0200;
    drive(1, 0, 30'h0, 0, 30'h0, 1, 32'h4800_0041);
    tick();
    checks++; if (imem.req !== 1'b0) begin errors++; $display("FAIL fsh_hold_req got %b exp 0", imem.req); end
    drive(1, 1, 30'h200, 0, 30'h0, 0, 32'h0);
    tick();
    checks++; if (if_en !== 1'b0) begin errors++; $display("FAIL fsh_en got %b exp 0", if_en); end
    checks++; if (imem.req !== 1'b1) begin errors++; $display("FAIL fsh_req got %b exp 1", imem.req); end
    checks++; if (imem.addr !== 30'h200) begin errors++; $display("FAIL fsh_addr got %h exp 200", imem.addr); end
    drive(0, 0, 30'h0, 0, 30'h0, 1, k);
    tick();
    checks++; if (if_insn !== k) begin errors++; $display("FAIL fsh_insn got %h exp %h", if_insn, k); end
    checks++; if (if_pc !== 30'h201) begin errors++; $display("FAIL fsh_pc got %h exp 201", if_pc); end
  endtask

  task automatic test_flush_ack_same();
    logic [31:0] l;
    l = 32'h1100_0055;
    drive(0, 1, 30'h55, 0, 30'h0, 1, 32'hBAD0_0201);
    tick();
    checks++; if (if_en !== 1'b0) begin errors++; $display("FAIL fa_en got %b exp 0", if_en); end
    checks++; if (if_insn !== NOP) begin errors++; $display("FAIL fa_insn got %h exp %h", if_insn, NOP); end
    checks++; if (imem.addr !== 30'h55) begin errors++; $display("FAIL fa_addr got %h exp 55", imem.addr); end
    drive(0, 0, 30'h0, 0, 30'h0, 1, l);
    tick();
    checks++; if (if_insn !== l) begin errors++; $display("FAIL fa_next_insn got %h exp %h", if_insn, l); end
    checks++; if (if_pc !== 30'h56) begin errors++; $display("FAIL fa_next_pc got %h exp 56", if_pc); end
  endtask

  task automatic test_reset_mid_drop();
    logic [31:0] m;
    m = 32'h3300_0000;
    drive(0, 0, 30'h0, 1, 30'h300, 0, 32'h0);
    tick();
    drive(0, 0, 30'h0, 0, 30'h0, 0, 32'h0);
    checks++; if (imem.addr !== 30'h56) begin errors++; $display("FAIL rd_drop_addr got %h exp 56", imem.addr); end
    reset = 1'b1;
    drive(0, 0, 30'h0, 0, 30'h0, 0, 32'h0);
    checks++; if (imem.req !== 1'b0) begin errors++; $display("FAIL rd_req got %b exp 0", imem.req); end
    tick();
    checks++; if (if_en !== 1'b0) begin errors++; $display("FAIL rd_en got %b exp 0", if_en); end
    checks++; if (if_insn !== NOP) begin errors++; $display("FAIL rd_insn got %h exp %h", if_insn, NOP); end
    checks++; if (imem.addr !== RST_PC) begin errors++; $display("FAIL rd_addr got %h exp %h", imem.addr, RST_PC); end
    reset = 1'b0;
    drive(0, 0, 30'h0, 0, 30'h0, 1, m);
    checks++; if (imem.req !== 1'b1) begin errors++; $display("FAIL rd_req_after got %b exp 1", imem.req); end
    tick();
    checks++; if (if_insn !== m) begin errors++; $display("FAIL rd_insn_after got %h exp %h", if_insn, m); end
    checks++; if (if_pc !== 30'h1) begin errors++; $display("FAIL rd_pc_after got %h exp 1", if_pc); end
  endtask

  task automatic test_wrap();
    logic [31:0] w;
    w = 32'h7777_FFFF;
    drive(0, 0, 30'h0, 1, 30'h3FFF_FFFF, 1, 32'hBAD0_0001);
    tick();
    drive(0, 0, 30'h0, 0, 30'h0, 1, w);
    checks++; if (imem.addr !== 30'h3FFF_FFFF) begin errors++; $display("FAIL wr_addr got %h exp 3fffffff", imem.addr); end
    tick();
    checks++; if (if_pc !== 30'h0) begin errors++; $display("FAIL wr_pc got %h exp 0", if_pc); end
    checks++; if (if_insn !== w) begin errors++; $display("FAIL wr_insn got %h exp %h", if_insn, w); end
    checks++; if (imem.addr !== 30'h0) begin errors++; $display("FAIL wr_next_addr got %h exp 0", imem.addr); end
  endtask

  function automatic logic [29:0] pick_addr();
    logic [31:0] r;
    r = $urandom;
    if (r[1:0] == 2'd0) return 30'h3FFF_FFFF - 30'(r[3:2]);
    return r[31:2];
  endfunction

  // Model view: the fetcher either has an abandoned read still in flight,
  // has a fetched word parked for a stalled decode, or is fetching at pc.
  task automatic test_random();
    logic [29:0] m_pc, m_out_pc, orphan_addr, buf_pc, e_addr, npc, ba, tgt;
    logic [31:0] m_out_insn, buf_insn, data;
    logic        m_out_en, orphan, buf_v, e_req, e_busy, st, fl, br, ack, redirect;
    reset = 1'b1;
    drive(0, 0, 30'h0, 0, 30'h0, 0, 32'h0);
    tick();
    reset = 1'b0;
    m_pc = RST_PC; m_out_pc = RST_PC; m_out_insn = NOP; m_out_en = 1'b0;
    orphan = 1'b0; orphan_addr = '0; buf_v = 1'b0; buf_pc = '0; buf_insn = '0;
    for (int n = 0; n < 3000; n++) begin
      st  = ($urandom % 4) == 0;
      fl  = ($urandom % 12) == 0;
      br  = ($urandom % 6) == 0;
      ack = ($urandom % 5) < 3;
      npc = pick_addr();
      ba  = pick_addr();
      e_req  = !buf_v;
      e_addr = orphan ? orphan_addr : m_pc;
      e_busy = orphan ? 1'b1 : (buf_v ? 1'b0 : !ack);
      data   = mem_word(e_addr);
      drive(st, fl, npc, br, ba, ack, data);
      checks++; if (imem.req !== e_req) begin errors++; $display("FAIL rnd_req @%0d got %b exp %b", n, imem.req, e_req); end
      if (e_req) begin
        checks++; if (imem.addr !== e_addr) begin errors++; $display("FAIL rnd_addr @%0d got %h exp %h", n, imem.addr, e_addr); end
      end
      checks++; if (if_busy !== e_busy) begin errors++; $display("FAIL rnd_busy @%0d got %b exp %b", n, if_busy, e_busy); end
      checks++; if (if_en !== m_out_en) begin errors++; $display("FAIL rnd_en @%0d got %b exp %b", n, if_en, m_out_en); end
      if (m_out_en) begin
        checks++; if (if_insn !== m_out_insn) begin errors++; $display("FAIL rnd_insn @%0d got %h exp %h", n, if_insn, m_out_insn); end
        checks++; if (if_pc !== m_out_pc) begin errors++; $display("FAIL rnd_pc @%0d got %h exp %h", n, if_pc, m_out_pc); end
      end
      redirect = fl || (!st && br);
      tgt = fl ? npc : ba;
      if (orphan) begin
        if (redirect) m_pc = tgt;
        if (ack) orphan = 1'b0;
        m_out_en = 1'b0;
      end else if (buf_v) begin
        if (redirect) begin
          m_pc = tgt; buf_v = 1'b0; m_out_en = 1'b0;
        end else if (!st) begin
          m_out_insn = buf_insn; m_out_pc = buf_pc; m_out_en = 1'b1; buf_v = 1'b0;
        end
      end else begin
        if (redirect) begin
          if (!ack) begin orphan = 1'b1; orphan_addr = m_pc; end
          m_pc = tgt; m_out_en = 1'b0; m_out_insn = NOP;
        end else if (st) begin
          if (ack) begin buf_v = 1'b1; buf_insn = data; buf_pc = m_pc + 30'd1; m_pc = m_pc + 30'd1; end
        end else if (ack) begin
          m_out_insn = data; m_out_pc = m_pc + 30'd1; m_out_en = 1'b1; m_pc = m_pc + 30'd1;
        end else begin
          m_out_en = 1'b0; m_out_insn = NOP;
        end
      end
      tick();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    stall = 1'b0; flush = 1'b0; br_taken = 1'b0;
    new_pc = '0; br_addr = '0;
    imem.ack = 1'b0; imem.rd_data = '0;
    #2;
    test_reset();
    test_zero_wait();
    test_stall_hold();
    test_branch();
    test_flush_drop();
    test_flush_stall_hold();
    test_flush_ack_same();
    test_reset_mid_drop();
    test_wrap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
